// File: rtl/mem_resp_ctrl_if.sv
// Load/store request bus between the MEM pipeline stage (master) and the
// memory-side responder mem_resp_ctrl (slave).
interface mem_resp_ctrl_if #(
    parameter int TYPE_W = 2
);
    logic              req_read;
    logic              req_write;
    logic [TYPE_W-1:0] req_type;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              misalign_err;

    modport master (
        output req_read, req_write, req_type, req_addr, req_wdata,
        input  rdata, busy, misalign_err
    );

    modport slave (
        input  req_read, req_write, req_type, req_addr, req_wdata,
        output rdata, busy, misalign_err
    );
endinterface

// File: rtl/mem_resp_ctrl.sv
// Serialises one b/h/w load or store onto a byte-wide single-port RAM with 1-cycle read latency.
// Optional MEM_RESP_ALIGN_CHECK_EN: misaligned h/w requests are rejected with a misalign_err pulse.
module mem_resp_ctrl #(
    parameter int ADDR_W = 17,
    parameter int TYPE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_resp_ctrl_if.slave    req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [TYPE_W-1:0] SZ_NONE = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] SZ_B    = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] SZ_H    = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] SZ_W    = TYPE_W'(3);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [TYPE_W-1:0] type_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       rdata_q;

    logic [2:0]        nbytes;
    logic              accept;
    logic              misaligned;
    logic [ADDR_W-1:0] addr_cur;
    logic [31:0]       rbuf_next;
    logic              busy_c;

    // Only the low ADDR_W address bits reach the RAM.
    wire unused_addr_hi = ^req.req_addr[31:ADDR_W];

    assign accept   = (req.req_read | req.req_write) && (req.req_type != SZ_NONE);
    assign addr_cur = base_q + ADDR_W'(cnt_q);

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign misaligned = ((req.req_type == SZ_H) && req.req_addr[0]) ||
                        ((req.req_type == SZ_W) && (req.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        case (type_q)
            SZ_B:    nbytes = 3'd1;
            SZ_H:    nbytes = 3'd2;
            SZ_W:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    // ram_din carries the byte addressed in the previous cycle, so count c stores byte c-1.
    always_comb begin
        rbuf_next = rbuf_q;
        case (cnt_q)
            3'd1:    rbuf_next[7:0]   = ram_din;
            3'd2:    rbuf_next[15:8]  = ram_din;
            3'd3:    rbuf_next[23:16] = ram_din;
            3'd4:    rbuf_next[31:24] = ram_din;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational block assigns a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = DONE;
                    end else if (req.req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (cnt_q == nbytes) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (cnt_q == nbytes - 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_dout = 8'h00;
        case (state_q)
            // Combinational so the requester stalls in the cycle it asks; held low while in reset.
            IDLE: busy_c = rst_n && accept;
            READ: begin
                busy_c   = 1'b1;
                ram_addr = addr_cur;
            end
            WRITE: begin
                busy_c   = 1'b1;
                ram_wr   = 1'b1;
                ram_addr = addr_cur;
                ram_dout = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            base_q  <= '0;
            type_q  <= SZ_NONE;
            wdata_q <= 32'h0;
            rbuf_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q   <= 3'd0;
                        base_q  <= req.req_addr[ADDR_W-1:0];
                        type_q  <= req.req_type;
                        wdata_q <= req.req_wdata;
                        rbuf_q  <= 32'h0;
                        if (misaligned && !req.req_write) begin
                            rdata_q <= 32'h0;
                        end
                    end
                end
                READ: begin
                    cnt_q  <= cnt_q + 3'd1;
                    rbuf_q <= rbuf_next;
                    // rdata only moves when a load completes; stores leave it alone.
                    if (cnt_q == nbytes) begin
                        rdata_q <= rbuf_next;
                    end
                end
                WRITE:   cnt_q <= cnt_q + 3'd1;
                default: cnt_q <= 3'd0;
            endcase
        end
    end

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE) begin
            err_q <= accept && misaligned;
        end
    end

    assign req.misalign_err = (state_q == DONE) && err_q;
`else
    assign req.misalign_err = 1'b0;
`endif

    assign req.busy  = busy_c;
    assign req.rdata = rdata_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed self-checking bench for mem_resp_ctrl with a byte-wide RAM model (1-cycle read latency).
module tb_mem_resp_ctrl;
    localparam int ADDR_W = 17;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;

    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W+7:0] wr_log [$];
    logic [ADDR_W-1:0] addr_log [$];

    int                pass_cnt = 0;
    int                total_cnt = 0;
    int                nbusy;
    logic [31:0]       done_rdata;
    logic              done_err;

    mem_resp_ctrl_if #(.TYPE_W(2)) bus ();

    mem_resp_ctrl #(.ADDR_W(ADDR_W), .TYPE_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .ram_wr   (ram_wr),
        .ram_din  (ram_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model with a backdoor port used only for preloading.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_wr) begin
            mem[ram_addr] <= ram_dout;
            wr_log.push_back({ram_addr, ram_dout});
        end
        ram_din <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Drives one request, holds it while busy, returns busy length and DONE-cycle outputs.
    task automatic run_req(input logic rd, input logic wr, input logic [1:0] ty,
                           input logic [31:0] addr, input logic [31:0] wd);
        addr_log.delete();
        wr_log.delete();
        @(negedge clk);
        bus.req_read = rd; bus.req_write = wr; bus.req_type = ty;
        bus.req_addr = addr; bus.req_wdata = wd;
        nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!bus.busy) break;
            nbusy++;
            if (k > 0) addr_log.push_back(ram_addr);
            @(negedge clk);
        end
        done_rdata = bus.rdata;
        done_err   = bus.misalign_err;
        bus.req_read = 1'b0; bus.req_write = 1'b0; bus.req_type = 2'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = 8'h00;
        bus.req_read = 1'b0; bus.req_write = 1'b1; bus.req_type = 2'd3;
        bus.req_addr = 32'h55; bus.req_wdata = 32'hFFFF_FFFF;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (ram_wr !== 1'b0) $display("FAIL rst_ram_wr got %b want 0", ram_wr); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", bus.rdata); else pass_cnt++;
        total_cnt++; if (ram_addr !== '0) $display("FAIL rst_ram_addr got %h want 0", ram_addr); else pass_cnt++;
        total_cnt++; if (bus.misalign_err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.misalign_err); else pass_cnt++;
        poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
        poke(17'h104, 8'h55); poke(17'h105, 8'h66);
        poke(17'h40, 8'hA5); poke(17'h41, 8'hA5); poke(17'h42, 8'hA5); poke(17'h43, 8'hA5);
        #1;
        total_cnt++; if (wr_log.size() !== 0) $display("FAIL rst_no_write got %0d writes want 0", wr_log.size()); else pass_cnt++;
        @(negedge clk);
        bus.req_write = 1'b0; bus.req_type = 2'd0; rst_n = 1'b1;
    endtask

    task automatic test_load_word;
        run_req(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        total_cnt++; if (nbusy !== 6) $display("FAIL lw_busy got %0d want 6", nbusy); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (addr_log.size() <= i || addr_log[i] !== ADDR_W'(32'h100 + i))
                $display("FAIL lw_addr%0d got %h want %h", i, (addr_log.size() > i) ? addr_log[i] : '0, 32'h100 + i);
            else pass_cnt++;
        end
        total_cnt++; if (wr_log.size() !== 0) $display("FAIL lw_no_write got %0d want 0", wr_log.size()); else pass_cnt++;
        total_cnt++; if (done_rdata !== 32'h4433_2211) $display("FAIL lw_rdata got %h want 44332211", done_rdata); else pass_cnt++;
        total_cnt++; if (done_err !== 1'b0) $display("FAIL lw_err got %b want 0", done_err); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (bus.rdata !== 32'h4433_2211) $display("FAIL lw_hold got %h want 44332211", bus.rdata); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL lw_idle_busy got %b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_store_byte;
        run_req(1'b0, 1'b1, 2'd1, 32'h20, 32'h1234_56AB);
        total_cnt++; if (nbusy !== 2) $display("FAIL sb_busy got %0d want 2", nbusy); else pass_cnt++;
        total_cnt++; if (wr_log.size() !== 1) $display("FAIL sb_nwr got %0d want 1", wr_log.size()); else pass_cnt++;
        total_cnt++; if (wr_log.size() < 1 || wr_log[0] !== {17'h20, 8'hAB})
            $display("FAIL sb_write got %h want %h", (wr_log.size() > 0) ? wr_log[0] : '0, {17'h20, 8'hAB}); else pass_cnt++;
        total_cnt++; if (done_rdata !== 32'h4433_2211) $display("FAIL sb_rdata got %h want 44332211", done_rdata); else pass_cnt++;
    endtask

    task automatic test_store_half_wrap;
        run_req(1'b0, 1'b1, 2'd2, 32'h0001_FFFF, 32'h0000_BEEF);
        total_cnt++; if (nbusy !== 3) $display("FAIL shw_busy got %0d want 3", nbusy); else pass_cnt++;
        total_cnt++; if (wr_log.size() !== 2) $display("FAIL shw_nwr got %0d want 2", wr_log.size()); else pass_cnt++;
        total_cnt++; if (wr_log.size() < 2 || wr_log[0] !== {17'h1FFFF, 8'hEF} || wr_log[1] !== {17'h0, 8'hBE})
            $display("FAIL shw_writes got %h,%h want %h,%h", (wr_log.size() > 0) ? wr_log[0] : '0,
                     (wr_log.size() > 1) ? wr_log[1] : '0, {17'h1FFFF, 8'hEF}, {17'h0, 8'hBE});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_loads;
        run_req(1'b1, 1'b0, 2'd2, 32'h0001_FFFF, 32'h0);
        total_cnt++; if (nbusy !== 4) $display("FAIL lhw_busy got %0d want 4", nbusy); else pass_cnt++;
        total_cnt++; if (addr_log.size() < 2 || addr_log[1] !== 17'h0)
            $display("FAIL lhw_wrap_addr got %h want 0", (addr_log.size() > 1) ? addr_log[1] : '1); else pass_cnt++;
        total_cnt++; if (done_rdata !== 32'h0000_BEEF) $display("FAIL lhw_rdata got %h want 0000beef", done_rdata); else pass_cnt++;
        run_req(1'b1, 1'b0, 2'd1, 32'h20, 32'h0);
        total_cnt++; if (nbusy !== 3) $display("FAIL lb_busy got %0d want 3", nbusy); else pass_cnt++;
        total_cnt++; if (done_rdata !== 32'h0000_00AB) $display("FAIL lb_rdata got %h want 000000ab", done_rdata); else pass_cnt++;
    endtask

    task automatic test_write_wins;
        run_req(1'b1, 1'b1, 2'd1, 32'h30, 32'h0000_005A);
        total_cnt++; if (nbusy !== 2) $display("FAIL ww_busy got %0d want 2", nbusy); else pass_cnt++;
        total_cnt++; if (wr_log.size() !== 1 || wr_log[0] !== {17'h30, 8'h5A})
            $display("FAIL ww_write got %0d writes first %h want 1 write %h", wr_log.size(),
                     (wr_log.size() > 0) ? wr_log[0] : '0, {17'h30, 8'h5A});
        else pass_cnt++;
        total_cnt++; if (done_rdata !== 32'h0000_00AB) $display("FAIL ww_rdata got %h want 000000ab", done_rdata); else pass_cnt++;
    endtask

    task automatic test_type_none;
        wr_log.delete();
        @(negedge clk);
        bus.req_read = 1'b1; bus.req_write = 1'b1; bus.req_type = 2'd0; bus.req_addr = 32'h100;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL tn_busy0 got %b want 0", bus.busy); else pass_cnt++;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (bus.busy !== 1'b0 || ram_addr !== '0 || wr_log.size() !== 0)
            $display("FAIL tn_idle got busy=%b addr=%h nwr=%0d want 0/0/0", bus.busy, ram_addr, wr_log.size());
        else pass_cnt++;
        bus.req_read = 1'b0; bus.req_write = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        wr_log.delete();
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_type = 2'd3; bus.req_addr = 32'h40; bus.req_wdata = 32'hDDCC_BBAA;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (ram_wr !== 1'b1 || ram_addr !== 17'h42 || ram_dout !== 8'hCC)
            $display("FAIL rmw_third got wr=%b addr=%h dout=%h want 1/00042/cc", ram_wr, ram_addr, ram_dout);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (ram_wr !== 1'b0) $display("FAIL rmw_async_wr got %b want 0", ram_wr); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0 || bus.rdata !== 32'h0)
            $display("FAIL rmw_idle got busy=%b rdata=%h want 0/0", bus.busy, bus.rdata); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (mem[17'h40] !== 8'hAA || mem[17'h41] !== 8'hBB)
            $display("FAIL rmw_written got %h%h want aabb", mem[17'h40], mem[17'h41]); else pass_cnt++;
        total_cnt++; if (mem[17'h42] !== 8'hA5 || mem[17'h43] !== 8'hA5)
            $display("FAIL rmw_untouched got %h%h want a5a5", mem[17'h42], mem[17'h43]); else pass_cnt++;
        bus.req_write = 1'b0; bus.req_type = 2'd0; rst_n = 1'b1;
        run_req(1'b1, 1'b0, 2'd1, 32'h41, 32'h0);
        total_cnt++; if (nbusy !== 3 || done_rdata !== 32'h0000_00BB)
            $display("FAIL rmw_resume got busy=%0d rdata=%h want 3/000000bb", nbusy, done_rdata); else pass_cnt++;
    endtask

    task automatic test_misalign;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        run_req(1'b1, 1'b0, 2'd3, 32'h102, 32'h0);
        total_cnt++; if (nbusy !== 1) $display("FAIL ma_busy got %0d want 1", nbusy); else pass_cnt++;
        total_cnt++; if (addr_log.size() !== 0 || wr_log.size() !== 0)
            $display("FAIL ma_no_ram got %0d addrs %0d writes want 0/0", addr_log.size(), wr_log.size()); else pass_cnt++;
        total_cnt++; if (done_err !== 1'b1) $display("FAIL ma_err got %b want 1", done_err); else pass_cnt++;
        total_cnt++; if (done_rdata !== 32'h0) $display("FAIL ma_rdata got %h want 0", done_rdata); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (bus.misalign_err !== 1'b0) $display("FAIL ma_pulse got %b want 0", bus.misalign_err); else pass_cnt++;
        run_req(1'b1, 1'b0, 2'd1, 32'h103, 32'h0);
        total_cnt++; if (nbusy !== 3 || done_rdata !== 32'h0000_0044 || done_err !== 1'b0)
            $display("FAIL ma_lb got busy=%0d rdata=%h err=%b want 3/00000044/0", nbusy, done_rdata, done_err); else pass_cnt++;
        run_req(1'b0, 1'b1, 2'd2, 32'h41, 32'h0000_7788);
        total_cnt++; if (nbusy !== 1 || wr_log.size() !== 0 || done_err !== 1'b1 || done_rdata !== 32'h0000_0044)
            $display("FAIL ma_sh got busy=%0d nwr=%0d err=%b rdata=%h want 1/0/1/00000044",
                     nbusy, wr_log.size(), done_err, done_rdata);
        else pass_cnt++;
`else
        run_req(1'b1, 1'b0, 2'd3, 32'h102, 32'h0);
        total_cnt++; if (nbusy !== 6) $display("FAIL ua_busy got %0d want 6", nbusy); else pass_cnt++;
        total_cnt++; if (done_rdata !== 32'h6655_4433) $display("FAIL ua_rdata got %h want 66554433", done_rdata); else pass_cnt++;
        total_cnt++; if (done_err !== 1'b0) $display("FAIL ua_err got %b want 0", done_err); else pass_cnt++;
        run_req(1'b0, 1'b1, 2'd2, 32'h41, 32'h0000_7788);
        total_cnt++; if (nbusy !== 3 || wr_log.size() !== 2 || wr_log[0] !== {17'h41, 8'h88} || wr_log[1] !== {17'h42, 8'h77})
            $display("FAIL ua_sh got busy=%0d nwr=%0d want 3/2 writes 41:88 42:77", nbusy, wr_log.size());
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_store_half_wrap();
        test_back_to_back_loads();
        test_write_wins();
        test_type_none();
        test_reset_mid_write();
        test_misalign();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
